// File: rtl/hb_pkg.sv
// Shared half-band helpers: accumulator sizing, rounding constant, signed
// saturation and the default coefficient set used by interpolator and decimator.
package hb_pkg;

  localparam int HB_NUM_COE = 5;
  localparam int HB_COE_DEFAULT [HB_NUM_COE] = '{952, -1609, 3090, -6260, 20622};

  typedef struct packed {
    logic signed [63:0] value;
    logic               ovf;
  } sat_t;

  function automatic int acc_width(input int xin, input int coe, input int n);
    return xin + coe + 2 + $clog2(n);
  endfunction

  function automatic logic signed [63:0] round_const(input int sra);
    return 64'sd1 <<< (sra - 1);
  endfunction

  function automatic sat_t sat_signed(input logic signed [63:0] v, input int out_width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_t               r;
    hi = (64'sd1 <<< (out_width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) begin
      r.value = hi;
      r.ovf   = 1'b1;
    end else if (v < lo) begin
      r.value = lo;
      r.ovf   = 1'b1;
    end else begin
      r.value = v;
      r.ovf   = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/hb_dn2_tap.sv
// One systolic stage of the half-band decimator: registered pre-add of a
// symmetric sample pair, registered coefficient multiply, registered cascade add.
module hb_dn2_tap #(
  parameter int XIN_WIDTH = 16,
  parameter int COE_WIDTH = 16,
  parameter int ACC_WIDTH = 37,
  parameter int COE       = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ce,
  input  logic signed [XIN_WIDTH-1:0] a,
  input  logic signed [XIN_WIDTH-1:0] b,
  input  logic signed [ACC_WIDTH-1:0] cin,
  output logic signed [ACC_WIDTH-1:0] cout
);

  localparam int PRE_W  = XIN_WIDTH + 1;
  localparam int PROD_W = XIN_WIDTH + COE_WIDTH + 1;
  localparam logic signed [COE_WIDTH-1:0] C = COE_WIDTH'(COE);

  logic signed [PRE_W-1:0]  pre_q;
  logic signed [PROD_W-1:0] prod_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      prod_q <= '0;
      cout   <= '0;
    end else if (ce) begin
      pre_q  <= PRE_W'(a) + PRE_W'(b);
      prod_q <= PROD_W'(pre_q) * PROD_W'(C);
      cout   <= cin + ACC_WIDTH'(prod_q);
    end
  end

endmodule

// File: rtl/hb_dn2.sv
// Half-band decimate-by-2: two input phases per beat, one rounded and
// saturated output per beat after an LAT-beat fill, systolic tap chain.
module hb_dn2
  import hb_pkg::*;
#(
  parameter int XIN_WIDTH      = 16,
  parameter int COE_WIDTH      = 16,
  parameter int NUM_UNIQUE_COE = HB_NUM_COE,
  parameter int COE_NUMS [NUM_UNIQUE_COE] = HB_COE_DEFAULT,
  parameter int YOUT_WIDTH     = 16,
  parameter int SRA_BITS       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  xin_valid,
  input  logic [XIN_WIDTH-1:0]  xin0,
  input  logic [XIN_WIDTH-1:0]  xin1,
  output logic                  yout_valid,
  output logic [YOUT_WIDTH-1:0] yout,
  output logic                  ovf
);

  localparam int N         = NUM_UNIQUE_COE;
  localparam int ACC_WIDTH = acc_width(XIN_WIDTH, COE_WIDTH, NUM_UNIQUE_COE);
  localparam int LAT       = N + 3;
  localparam int CNT_W     = $clog2(LAT + 1);
  localparam int X0_LEN    = 2 * N - 1;
  localparam int X1_LEN    = N + 2;
  localparam logic signed [ACC_WIDTH-1:0] RND = ACC_WIDTH'(round_const(SRA_BITS));

  logic signed [XIN_WIDTH-1:0] x0_s;
  logic signed [XIN_WIDTH-1:0] x1_s;
  logic signed [XIN_WIDTH-1:0] x0_dl [X0_LEN];
  logic signed [XIN_WIDTH-1:0] x1_dl [X1_LEN];
  logic signed [ACC_WIDTH-1:0] casc  [N+1];
  logic signed [ACC_WIDTH-1:0] sh_q;
  logic [CNT_W-1:0]            fill_q;
  logic                        emit;
  sat_t                        sat_r;

  assign x0_s = xin0;
  assign x1_s = xin1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < X0_LEN; i++) x0_dl[i] <= '0;
      for (int unsigned i = 0; i < X1_LEN; i++) x1_dl[i] <= '0;
    end else if (xin_valid) begin
      x0_dl[0] <= x0_s;
      x1_dl[0] <= x1_s;
      for (int unsigned i = 1; i < X0_LEN; i++) x0_dl[i] <= x0_dl[i-1];
      for (int unsigned i = 1; i < X1_LEN; i++) x1_dl[i] <= x1_dl[i-1];
    end
  end

  // Cascade skew: tap k sees x0 delayed 2k while the far-end sample is shared,
  // and the centre term enters at the chain head delayed N+2 so all terms of
  // one output beat meet at the last tap.
  assign casc[0] = ACC_WIDTH'(x1_dl[X1_LEN-1]) <<< (SRA_BITS - 1);

  for (genvar k = 0; k < N; k++) begin : g_tap
    logic signed [XIN_WIDTH-1:0] a;
    if (k == 0) begin : g_head
      assign a = x0_s;
    end else begin : g_body
      assign a = x0_dl[2*k-1];
    end
    hb_dn2_tap #(
      .XIN_WIDTH(XIN_WIDTH),
      .COE_WIDTH(COE_WIDTH),
      .ACC_WIDTH(ACC_WIDTH),
      .COE      (COE_NUMS[k])
    ) u_tap (
      .clk  (clk),
      .rst_n(rst_n),
      .ce   (xin_valid),
      .a    (a),
      .b    (x0_dl[X0_LEN-1]),
      .cin  (casc[k]),
      .cout (casc[k+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q <= '0;
    end else if (xin_valid) begin
      sh_q <= (casc[N] + RND) >>> SRA_BITS;
    end
  end

  always_comb begin
    sat_r = sat_signed(64'(sh_q), YOUT_WIDTH);
  end

  assign emit = xin_valid && (fill_q == CNT_W'(LAT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q     <= '0;
      yout_valid <= 1'b0;
      yout       <= '0;
      ovf        <= 1'b0;
    end else begin
      if (xin_valid && (fill_q != CNT_W'(LAT))) fill_q <= fill_q + CNT_W'(1);
      yout_valid <= emit;
      if (emit) begin
        yout <= YOUT_WIDTH'(sat_r.value);
        ovf  <= sat_r.ovf;
      end
    end
  end

endmodule

// File: tb/tb_hb_dn2.sv
// Self-checking bench for hb_dn2: constant vector table, directed corner
// sequences and random traffic against a direct-form reference model.
module tb_hb_dn2;

  localparam int N   = 5;
  localparam int LAT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        xin_valid = 1'b0;
  logic [15:0] xin0 = '0;
  logic [15:0] xin1 = '0;
  logic        yout_valid;
  logic [15:0] yout;
  logic        ovf;

  hb_dn2 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .xin_valid (xin_valid),
    .xin0      (xin0),
    .xin1      (xin1),
    .yout_valid(yout_valid),
    .yout      (yout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int     n_tests = 0;
  int     n_fail  = 0;
  int     coe [N] = '{952, -1609, 3090, -6260, 20622};
  longint q0 [$];
  longint q1 [$];
  longint last_y = 0;
  logic   last_o = 1'b0;

  typedef struct {
    logic v;
    int   x0;
    int   x1;
    logic ev;
    int   ey;
    logic eo;
  } vec_t;

  vec_t tbl [20];
  int   imp [10] = '{15, -25, 47, -96, 315, 315, -96, 47, -25, 15};

  task automatic chk(input string name, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic longint x0at(input int i);
    return (i < 0) ? 64'sd0 : q0[i];
  endfunction

  function automatic longint x1at(input int i);
    return (i < 0) ? 64'sd0 : q1[i];
  endfunction

  // Direct evaluation of the half-band sum, round half up, clamp to 16 bits.
  task automatic model(input int j, output longint y, output logic o);
    longint acc;
    longint r;
    acc = x1at(j - N) * 32768;
    for (int k = 0; k < N; k++)
      acc += longint'(coe[k]) * (x0at(j - k) + x0at(j - (2*N - 1 - k)));
    r = (acc + 32768) >>> 16;
    o = 1'b0;
    if (r > 32767) begin r = 32767; o = 1'b1; end
    if (r < -32768) begin r = -32768; o = 1'b1; end
    y = r;
  endtask

  task automatic step(input logic v, input int a, input int b);
    longint ey;
    logic   eo;
    int     j;
    xin_valid = v;
    xin0 = 16'(a);
    xin1 = 16'(b);
    @(posedge clk);
    #1;
    if (v) begin
      q0.push_back(longint'(a));
      q1.push_back(longint'(b));
      j = q0.size() - 1;
      if (j >= LAT) begin
        model(j - LAT, ey, eo);
        chk("valid", longint'(yout_valid), 1);
        chk("yout", longint'($signed(yout)), ey);
        chk("ovf", longint'(ovf), longint'(eo));
        last_y = ey;
        last_o = eo;
      end else begin
        chk("fill_valid", longint'(yout_valid), 0);
        chk("fill_hold", longint'($signed(yout)), last_y);
      end
    end else begin
      chk("idle_valid", longint'(yout_valid), 0);
      chk("idle_hold", longint'($signed(yout)), last_y);
      chk("idle_ovf", longint'(ovf), longint'(last_o));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    xin_valid = 1'b0;
    xin0 = '0;
    xin1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", longint'(yout_valid), 0);
    chk("rst_yout", longint'($signed(yout)), 0);
    chk("rst_ovf", longint'(ovf), 0);
    q0.delete();
    q1.delete();
    last_y = 0;
    last_o = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint dc_ramp [$];
    longint ramp2 [$];
    longint got [$];
    int     first_idx;
    int     steps;
    logic   sent;
    logic   v;

    for (int i = 0; i < 20; i++) begin
      tbl[i] = '{v: 1'b1, x0: 0, x1: 0, ev: 1'b0, ey: 0, eo: 1'b0};
      if (i >= LAT) tbl[i].ev = 1'b1;
      if (i >= LAT && i < LAT + 10) tbl[i].ey = imp[i-LAT];
    end
    tbl[0].x0 = 1000;

    // Odd-branch impulse from the constant table.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].v, tbl[i].x0, tbl[i].x1);
      chk("tbl_valid", longint'(yout_valid), longint'(tbl[i].ev));
      chk("tbl_yout", longint'($signed(yout)), longint'(tbl[i].ey));
      chk("tbl_ovf", longint'(ovf), longint'(tbl[i].eo));
    end

    // Centre impulse: single 500 at beat 13.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 0, (i == 0) ? 1000 : 0);
      if (i >= LAT) chk("centre", longint'($signed(yout)), (i == 13) ? 500 : 0);
    end

    // DC 1000: first pulse on the 9th edge, steady 1013.
    do_reset();
    first_idx = -1;
    for (int i = 1; i <= 30; i++) begin
      step(1'b1, 1000, 1000);
      if (yout_valid && first_idx < 0) first_idx = i;
      if (yout_valid && dc_ramp.size() < 12) dc_ramp.push_back(longint'($signed(yout)));
    end
    chk("dc_first", longint'(first_idx), 9);
    chk("dc_steady", longint'($signed(yout)), 1013);
    chk("dc_ovf", longint'(ovf), 0);

    // Saturation, both rails.
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 32767, 32767);
    chk("sat_hi", longint'($signed(yout)), 32767);
    chk("sat_hi_ovf", longint'(ovf), 1);
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, -32768, -32768);
    chk("sat_lo", longint'($signed(yout)), -32768);
    chk("sat_lo_ovf", longint'(ovf), 1);

    // Gapped odd-branch impulse: same output sequence as continuous.
    do_reset();
    sent = 1'b0;
    steps = 0;
    while (got.size() < 12 && steps < 600) begin
      v = ($urandom_range(0, 99) < 30);
      step(v, (v && !sent) ? 1000 : 0, 0);
      if (v) sent = 1'b1;
      if (yout_valid) got.push_back(longint'($signed(yout)));
      steps++;
    end
    chk("gap_count", longint'(got.size()), 12);
    for (int i = 0; i < got.size(); i++)
      chk("gap_seq", got[i], (i < 10) ? longint'(imp[i]) : 0);

    // Reset mid-stream during DC 1000.
    do_reset();
    for (int i = 0; i < 15; i++) step(1'b1, 1000, 1000);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", longint'(yout_valid), 0);
    chk("mid_rst_yout", longint'($signed(yout)), 0);
    chk("mid_rst_ovf", longint'(ovf), 0);
    q0.delete();
    q1.delete();
    last_y = 0;
    last_o = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_hold", longint'(yout_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    steps = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1000, 1000);
      if (yout_valid) ramp2.push_back(longint'($signed(yout)));
      else if (ramp2.size() == 0) steps++;
    end
    chk("mid_rst_gap", longint'(steps), 8);
    for (int i = 0; i < 12 && i < ramp2.size(); i++)
      chk("mid_rst_ramp", ramp2[i], dc_ramp[i]);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 9) == 0)
        step(v, ($urandom_range(0, 1) != 0) ? 32767 : -32768,
             ($urandom_range(0, 1) != 0) ? 32767 : -32768);
      else
        step(v, int'($urandom_range(0, 65535)) - 32768,
             int'($urandom_range(0, 65535)) - 32768);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
